sqrt_iter_core: RTL

SQRT_ITER_CORE -- requirements
Module: sqrt_iter_core

---
 rtl/sqrt_pkg.sv | 22 ++
 rtl/sqrt_step.sv | 36 +++
 rtl/sqrt_iter_core.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the iterative square-root core:
//   state_t     - controller state (IDLE / CALC / DONE)
//   calc_iters  - number of CALC cycles for a given radicand width and
//                 root bits resolved per clock
// -----------------------------------------------------------------------------
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One root bit consumes two radicand bits; IPC root bits are resolved
    // per clock.
    function automatic int calc_iters(input int width, input int ipc);
        return width / (2 * ipc);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// -----------------------------------------------------------------------------
// sqrt_step
// One combinational digit step of the bit-serial integer square root.
//   rem_i   [ROOT_W+1:0] partial remainder going in
//   root_i  [ROOT_W-1:0] partial root going in
//   bits_i  [1:0]        next two radicand bits (MSB first)
//   rem_o   [ROOT_W+1:0] partial remainder after this step
//   root_o  [ROOT_W-1:0] partial root with one more bit appended
// -----------------------------------------------------------------------------
module sqrt_step #(
    parameter int ROOT_W = 8
) (
    input  logic [ROOT_W+1:0] rem_i,
    input  logic [ROOT_W-1:0] root_i,
    input  logic [1:0]        bits_i,
    output logic [ROOT_W+1:0] rem_o,
    output logic [ROOT_W-1:0] root_o
);

    localparam int RW = ROOT_W + 2;

    logic [RW-1:0] rem_shift;
    logic [RW-1:0] trial;
    logic          ge;

    always_comb begin
        // Before the step the remainder fits in ROOT_W bits, so shifting it
        // left by two inside RW bits loses nothing.
        rem_shift = (rem_i << 2) | {{(RW-2){1'b0}}, bits_i};
        trial     = {root_i, 2'b01};
        ge        = (rem_shift >= trial);
        rem_o     = ge ? (rem_shift - trial) : rem_shift;
        root_o    = {root_i[ROOT_W-2:0], ge};
    end

endmodule

// File: rtl/sqrt_iter_core.sv
// -----------------------------------------------------------------------------
// sqrt_iter_core
// Iterative unsigned integer square root: root = floor(sqrt(data)),
// rem = data - root^2. Resolves IPC root bits per clock, so a result appears
// WIDTH/(2*IPC) cycles after the accepting edge.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   radicand offered
//   in_ready_o   core can accept a radicand (also high in DONE when the
//                result is being taken the same cycle)
//   data_i       [WIDTH-1:0] radicand
//   out_valid_o  result available
//   out_ready_i  consumer takes result
//   root_o       [WIDTH/2-1:0] floor(sqrt(radicand))
//   rem_o        [WIDTH/2:0] radicand - root^2 (only with SQRT_REM_EN)
//   busy_o       high while computing
//
// Build option: define SQRT_REM_EN to expose the final remainder on rem_o.
// -----------------------------------------------------------------------------
module sqrt_iter_core
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IPC   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH/2-1:0] root_o,
`ifdef SQRT_REM_EN
    output logic [WIDTH/2:0]   rem_o,
`endif
    output logic               busy_o
);

    localparam int RTW   = WIDTH / 2;
    localparam int RW    = RTW + 2;
    localparam int L     = calc_iters(WIDTH, IPC);
    localparam int CNT_W = $clog2(L + 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("sqrt_iter_core: WIDTH must be even and >= 4");
    end
    if ((IPC != 1 && IPC != 2) || ((WIDTH / 2) % IPC) != 0) begin : g_bad_ipc
        $error("sqrt_iter_core: IPC must be 1 or 2 and divide WIDTH/2");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [RTW-1:0]   root_q, root_d;
    logic [RTW-1:0]   root_res_q, root_res_d;
`ifdef SQRT_REM_EN
    logic [RTW:0]     rem_res_q, rem_res_d;
`endif

    logic accept;

    // Chain of IPC digit steps; radicand bits are consumed MSB first from
    // the shifting copy in data_q.
    logic [RW-1:0]  rem_c  [IPC+1];
    logic [RTW-1:0] root_c [IPC+1];

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar g = 0; g < IPC; g++) begin : g_step
        sqrt_step #(
            .ROOT_W (RTW)
        ) u_step (
            .rem_i  (rem_c[g]),
            .root_i (root_c[g]),
            .bits_i (data_q[WIDTH-1-2*g -: 2]),
            .rem_o  (rem_c[g+1]),
            .root_o (root_c[g+1])
        );
    end

    // In DONE the core is ready only when the result leaves on this edge,
    // which lets a new radicand enter without an IDLE bubble.
    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == CALC);
    assign root_o      = root_res_q;
`ifdef SQRT_REM_EN
    assign rem_o       = rem_res_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rem_d      = rem_q;
        root_d     = root_q;
        root_res_d = root_res_q;
`ifdef SQRT_REM_EN
        rem_res_d  = rem_res_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = CALC;
                    data_d  = data_i;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CNT_W'(L);
                end else if (state_q == DONE && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                data_d = data_q << (2 * IPC);
                rem_d  = rem_c[IPC];
                root_d = root_c[IPC];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = DONE;
                    root_res_d = root_c[IPC];
`ifdef SQRT_REM_EN
                    rem_res_d  = rem_c[IPC][RTW:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            root_res_q <= '0;
`ifdef SQRT_REM_EN
            rem_res_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            root_res_q <= root_res_d;
`ifdef SQRT_REM_EN
            rem_res_q  <= rem_res_d;
`endif
        end
    end

endmodule
